// File: rtl/clk_div.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div
//  Description : Programmable clock divider. Produces a 50%-duty square wave
//                (sclclk) in the CLK domain whose half-period is clkscale CLK
//                cycles. clkscale == 0 parks the output low. The output is a
//                plain register, not a clock-tree net.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] clkscale,
    output logic             sclclk
);

    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic [WIDTH-1:0] r_cnt;
    logic             r_sclclk;
    logic             w_idle;
    logic [WIDTH-1:0] w_last;
    logic             w_end_half;

    // Decode the divider controls: idle flag, last count of a half-period and
    // whether the current edge closes the half-period. The ">=" comparison lets
    // a mid-count reduction of clkscale end the half-period at once instead of
    // letting the counter run up to its wrap point.
    always_comb begin
        w_idle     = (clkscale == c_ZERO);
        w_last     = clkscale - c_ONE;
        w_end_half = 1'b0;
        if (!w_idle) begin
            w_end_half = (r_cnt >= w_last);
        end
    end

    // Half-period counter and output register; idle forces a clean restart.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt    <= c_ZERO;
            r_sclclk <= 1'b0;
        end else if (w_idle) begin
            r_cnt    <= c_ZERO;
            r_sclclk <= 1'b0;
        end else if (w_end_half) begin
            r_cnt    <= c_ZERO;
            r_sclclk <= ~r_sclclk;
        end else begin
            r_cnt    <= r_cnt + c_ONE;
        end
    end

    assign sclclk = r_sclclk;

endmodule
`default_nettype wire

// File: tb/tb_clk_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div
//  Description : Self-checking bench for clk_div. A reference model tracks how
//                many edges of the current half-period have elapsed; scripted
//                scenarios pin exact edge numbers, then randomized clkscale
//                changes and reset pulses are checked cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div;

    localparam int WIDTH = 32;

    logic             CLK;
    logic             RST_N;
    logic [WIDTH-1:0] clkscale;
    logic             sclclk;

    int total;
    int bad;

    // Reference state: edges elapsed in the running half-period and the level
    longint unsigned m_elapsed;
    logic            m_out;

    clk_div #(.WIDTH(WIDTH)) u_dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clkscale (clkscale),
        .sclclk   (sclclk)
    );

    // 10 time-unit system clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: a half-period lasts clkscale edges; once that many
    // edges have elapsed the level flips and a new half-period starts.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_elapsed <= 0;
            m_out     <= 1'b0;
        end else if (clkscale == 0) begin
            m_elapsed <= 0;
            m_out     <= 1'b0;
        end else if (m_elapsed + 1 >= {32'd0, clkscale}) begin
            m_elapsed <= 0;
            m_out     <= ~m_out;
        end else begin
            m_elapsed <= m_elapsed + 1;
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: sclclk=%0b expected=%0b at t=%0t", name, act, exp, $time);
        end
    endtask

    // One CLK edge, then compare DUT against the model away from the edge
    task automatic tick();
        @(posedge CLK);
        #1;
        check("model", sclclk, m_out);
    endtask

    task automatic edges(input int n);
        repeat (n) tick();
    endtask

    // Called just after an edge; the next posedge becomes edge 1
    task automatic do_reset(input logic [WIDTH-1:0] scale);
        clkscale = scale;
        RST_N    = 1'b0;
        #2;
        RST_N    = 1'b1;
    endtask

    initial begin
        logic [7:0] pat;
        int         r;
        total    = 0;
        bad      = 0;
        RST_N    = 1'b0;
        clkscale = '0;
        #1;
        check("reset_state", sclclk, 1'b0);
        @(posedge CLK);
        #1;

        // Nominal divide by 500: edges 250 / 500 / 750
        do_reset(32'd250);
        edges(249); check("t2_e249", sclclk, 1'b0);
        edges(1);   check("t2_e250", sclclk, 1'b1);
        edges(249); check("t2_e499", sclclk, 1'b1);
        edges(1);   check("t2_e500", sclclk, 1'b0);
        edges(249); check("t2_e749", sclclk, 1'b0);
        edges(1);   check("t2_e750", sclclk, 1'b1);

        // Asynchronous reset mid-count while high
        edges(100); check("t1_pre", sclclk, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        check("t1_async", sclclk, 1'b0);
        #1;
        RST_N = 1'b1;
        edges(249); check("t1_e249", sclclk, 1'b0);
        edges(1);   check("t1_e250", sclclk, 1'b1);

        // clkscale=1 toggles each edge
        do_reset(32'd1);
        edges(1); check("t3_s1_e1", sclclk, 1'b1);
        edges(1); check("t3_s1_e2", sclclk, 1'b0);
        edges(1); check("t3_s1_e3", sclclk, 1'b1);
        edges(1); check("t3_s1_e4", sclclk, 1'b0);

        // clkscale=2 gives a 4-cycle period
        do_reset(32'd2);
        pat = 8'b0110_0110;
        for (int k = 0; k < 8; k++) begin
            edges(1);
            check("t3_s2", sclclk, pat[7-k]);
        end

        // clkscale=0 holds low, then 3 restarts cleanly
        clkscale = 32'd0;
        begin
            logic seen_high;
            seen_high = 1'b0;
            for (int k = 0; k < 1000; k++) begin
                tick();
                if (sclclk !== 1'b0) seen_high = 1'b1;
            end
            check("t4_idle_low", seen_high, 1'b0);
        end
        clkscale = 32'd3;
        edges(2); check("t4_e2", sclclk, 1'b0);
        edges(1); check("t4_e3", sclclk, 1'b1);

        // Lowering clkscale below the running count
        do_reset(32'd250);
        edges(100); check("t5_pre", sclclk, 1'b0);
        clkscale = 32'd10;
        edges(1);  check("t5_next", sclclk, 1'b1);
        edges(9);  check("t5_e10", sclclk, 1'b1);
        edges(1);  check("t5_e11", sclclk, 1'b0);
        edges(10); check("t5_e21", sclclk, 1'b1);

        // Raising clkscale extends the running half-period
        do_reset(32'd5);
        edges(3);
        clkscale = 32'd8;
        edges(4); check("t6_e7", sclclk, 1'b0);
        edges(1); check("t6_e8", sclclk, 1'b1);
        edges(7); check("t6_e15", sclclk, 1'b1);
        edges(1); check("t6_e16", sclclk, 1'b0);

        // Maximum half-period, then drop to 1 mid-count
        do_reset({WIDTH{1'b1}});
        edges(50); check("max_hold", sclclk, 1'b0);
        clkscale = 32'd1;
        edges(1);  check("max_drop", sclclk, 1'b1);

        // Randomized clkscale changes and reset pulses
        do_reset(32'd4);
        for (int i = 0; i < 6000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                clkscale = WIDTH'($urandom_range(0, 12));
            end else if (r == 4) begin
                clkscale = WIDTH'($urandom_range(13, 60));
            end else if (r == 5) begin
                #2;
                RST_N = 1'b0;
                #1;
                check("rand_async", sclclk, 1'b0);
                #2;
                RST_N = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
